// File: rtl/grayscale_bbox_tracker.sv
// Binarizes a grayscale pixel stream against a runtime threshold and publishes the
// bounding box and foreground count of every completed frame. Optional macro
// BBOX_NOISE_FILTER_EN: report object_found only when the count reaches min_count.
module grayscale_bbox_tracker #(
  parameter int rgb_width    = 10,
  parameter int frame_width  = 640,
  parameter int frame_height = 480,
  parameter int coord_width  = 10,
  parameter int count_width  = 19,
  parameter int min_count    = 16
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [rgb_width-1:0]   GRAYSCALE,
  input  logic [rgb_width-1:0]   THRESHOLD,
  input  logic                   valid_in,
  input  logic                   frame_start,
  output logic [coord_width-1:0] BOX_XMIN,
  output logic [coord_width-1:0] BOX_XMAX,
  output logic [coord_width-1:0] BOX_YMIN,
  output logic [coord_width-1:0] BOX_YMAX,
  output logic [count_width-1:0] PIXEL_COUNT,
  output logic                   object_found,
  output logic                   box_valid
);

  localparam logic [coord_width-1:0] X_LAST = coord_width'(frame_width - 1);
  localparam logic [coord_width-1:0] Y_LAST = coord_width'(frame_height - 1);
  localparam logic [coord_width-1:0] C_ONES = '1;
  localparam logic [coord_width-1:0] C_ZERO = '0;
  localparam logic [count_width-1:0] N_ZERO = '0;

  function automatic logic [coord_width-1:0] cmin(input logic [coord_width-1:0] a,
                                                 input logic [coord_width-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [coord_width-1:0] cmax(input logic [coord_width-1:0] a,
                                                 input logic [coord_width-1:0] b);
    return (b > a) ? b : a;
  endfunction

  logic [coord_width-1:0] x_p0, y_p0;
  logic [coord_width-1:0] acc_xmin_p0, acc_xmax_p0, acc_ymin_p0, acc_ymax_p0;
  logic [count_width-1:0] acc_count_p0;
  logic                   acc_seen_p0;

  logic [coord_width-1:0] px_x, px_y, nxt_x, nxt_y;
  logic [coord_width-1:0] base_xmin, base_xmax, base_ymin, base_ymax;
  logic [count_width-1:0] base_count;
  logic                   base_seen;
  logic [coord_width-1:0] mrg_xmin, mrg_xmax, mrg_ymin, mrg_ymax;
  logic [count_width-1:0] mrg_count;
  logic                   mrg_seen;
  logic                   fg, last_pix, found;

  // Stage p0: a frame_start pixel is evaluated as (0,0) against fresh accumulators
  always_comb begin
    px_x       = x_p0;
    px_y       = y_p0;
    base_xmin  = acc_xmin_p0;
    base_xmax  = acc_xmax_p0;
    base_ymin  = acc_ymin_p0;
    base_ymax  = acc_ymax_p0;
    base_count = acc_count_p0;
    base_seen  = acc_seen_p0;
    if (frame_start) begin
      px_x       = C_ZERO;
      px_y       = C_ZERO;
      base_xmin  = C_ONES;
      base_xmax  = C_ZERO;
      base_ymin  = C_ONES;
      base_ymax  = C_ZERO;
      base_count = N_ZERO;
      base_seen  = 1'b0;
    end

    fg = valid_in && (GRAYSCALE >= THRESHOLD);

    mrg_xmin  = base_xmin;
    mrg_xmax  = base_xmax;
    mrg_ymin  = base_ymin;
    mrg_ymax  = base_ymax;
    mrg_count = base_count;
    mrg_seen  = base_seen;
    if (fg) begin
      mrg_xmin  = cmin(base_xmin, px_x);
      mrg_xmax  = cmax(base_xmax, px_x);
      mrg_ymin  = cmin(base_ymin, px_y);
      mrg_ymax  = cmax(base_ymax, px_y);
      mrg_count = base_count + count_width'(1);
      mrg_seen  = 1'b1;
    end

    // frame_start overrides what would otherwise have been the closing pixel
    last_pix = valid_in && !frame_start && (x_p0 == X_LAST) && (y_p0 == Y_LAST);

    nxt_x = px_x + coord_width'(1);
    nxt_y = px_y;
    if (px_x == X_LAST) begin
      nxt_x = C_ZERO;
      nxt_y = (px_y == Y_LAST) ? C_ZERO : px_y + coord_width'(1);
    end
  end

`ifdef BBOX_NOISE_FILTER_EN
  localparam logic [count_width-1:0] MIN_CNT = count_width'(min_count);
  always_comb found = mrg_seen && (mrg_count >= MIN_CNT);
`else
  localparam bit unused_min_count = (min_count != 0);
  always_comb found = mrg_seen;
`endif

  // Stage p1: coordinate/accumulator update and result publication
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      x_p0         <= C_ZERO;
      y_p0         <= C_ZERO;
      acc_xmin_p0  <= C_ONES;
      acc_xmax_p0  <= C_ZERO;
      acc_ymin_p0  <= C_ONES;
      acc_ymax_p0  <= C_ZERO;
      acc_count_p0 <= N_ZERO;
      acc_seen_p0  <= 1'b0;
      BOX_XMIN     <= C_ZERO;
      BOX_XMAX     <= C_ZERO;
      BOX_YMIN     <= C_ZERO;
      BOX_YMAX     <= C_ZERO;
      PIXEL_COUNT  <= N_ZERO;
      object_found <= 1'b0;
      box_valid    <= 1'b0;
    end else begin
      box_valid <= last_pix;
      if (valid_in) begin
        x_p0 <= nxt_x;
        y_p0 <= nxt_y;
        if (last_pix) begin
          acc_xmin_p0  <= C_ONES;
          acc_xmax_p0  <= C_ZERO;
          acc_ymin_p0  <= C_ONES;
          acc_ymax_p0  <= C_ZERO;
          acc_count_p0 <= N_ZERO;
          acc_seen_p0  <= 1'b0;
          BOX_XMIN     <= found ? mrg_xmin : C_ZERO;
          BOX_XMAX     <= found ? mrg_xmax : C_ZERO;
          BOX_YMIN     <= found ? mrg_ymin : C_ZERO;
          BOX_YMAX     <= found ? mrg_ymax : C_ZERO;
          PIXEL_COUNT  <= mrg_seen ? mrg_count : N_ZERO;
          object_found <= found;
        end else begin
          acc_xmin_p0  <= mrg_xmin;
          acc_xmax_p0  <= mrg_xmax;
          acc_ymin_p0  <= mrg_ymin;
          acc_ymax_p0  <= mrg_ymax;
          acc_count_p0 <= mrg_count;
          acc_seen_p0  <= mrg_seen;
        end
      end
    end
  end

endmodule

// File: doc/grayscale_bbox_tracker.md
# grayscale_bbox_tracker

Consumes the thresholded-luma pixel stream from the grayscale conversion stage and detects a single bright object per frame. Each pixel is binarized against a runtime threshold. Raster coordinates are tracked internally. The bounding box and foreground pixel count of all foreground pixels are accumulated, and one result set is published per completed frame for the downstream tracking/overlay logic.

## Interface
- `rgb_width`, 10, pixel and threshold width.
- `frame_width`, 640, active pixels per line.
- `frame_height`, 480, active lines per frame.
- `coord_width`, 10, width of x/y coordinates. Must hold `max(frame_width, frame_height) - 1`.
- `count_width`, 19, width of the pixel counter. Must hold `frame_width*frame_height`.
- `min_count`, 16, noise-filter threshold. Used only when `BBOX_NOISE_FILTER_EN` is defined.
- `clk` in 1: rising-edge clock.
- `areset` in 1: asynchronous, active-high reset.
- `GRAYSCALE` in `rgb_width`: pixel value from the grayscale stage.
- `THRESHOLD` in `rgb_width`: foreground threshold, sampled on every accepted pixel.
- `valid_in` in 1: `GRAYSCALE` is valid this cycle.
- `frame_start` in 1: the accepted pixel is (0,0). Qualified by `valid_in`.
- `BOX_XMIN`, `BOX_XMAX`, `BOX_YMIN`, `BOX_YMAX` out `coord_width`: bounding box of the last completed frame.
- `PIXEL_COUNT` out `count_width`: foreground pixels in the last completed frame.
- `object_found` out 1: the last completed frame contained an object.
- `box_valid` out 1: one-cycle pulse when the result outputs update.

## Operation
- **Accepted pixel:** `valid_in`=1. Cycles with `valid_in`=0 change nothing except clearing `box_valid`.
- **Foreground test:** unsigned `GRAYSCALE >= THRESHOLD`.
- **Coordinate counters x, y:**
  - On each accepted pixel, x increments.
  - At x = `frame_width`-1, x wraps to 0 and y increments.
  - At the last pixel (x = `frame_width`-1, y = `frame_height`-1), both wrap to 0.
- **Accumulators:** xmin/ymin start at all-ones, xmax/ymax start at 0, count starts at 0, and the `seen` flag starts at 0. For each foreground pixel:
  - xmin = min(xmin, x); xmax = max(xmax, x).
  - ymin = min(ymin, y); ymax = max(ymax, y).
  - count += 1; `seen` = 1.
- **Frame complete (last pixel accepted):**
  - The final pixel's contribution is included.
  - The result registers load from the merged values.
  - Accumulators reinitialize in the same cycle.
  - `box_valid` pulses.
- **No object:** if `seen` = 0 at completion, the box outputs load 0, `PIXEL_COUNT` loads 0 and `object_found` = 0.
- **`frame_start` with `valid_in`:**
  - The pixel is treated as (0,0) of a new frame, with fresh accumulators; the pixel itself is included.
  - Any partial frame is discarded and no `box_valid` is issued for it.
  - If this coincides with what would have been the last pixel, `frame_start` wins and no `box_valid` is issued.
- **Result hold:** result outputs hold between `box_valid` pulses.
- **Reset:**
  - All outputs go to 0.
  - x = y = 0, and the accumulators go to their initial values.
  - Reset mid-frame discards the frame.

## Timing
- `box_valid` is registered. It is high the cycle after the clock edge that accepts the last pixel, and all result outputs are valid in that same cycle.
- Latency: 1 cycle from the last pixel to the result.
- `box_valid` stays high for exactly 1 cycle, even if `valid_in` stays high.
- Full throughput: one pixel per cycle, no backpressure, and no gaps are required between frames.
- Back-to-back frames produce pulses exactly `frame_width*frame_height` accepted pixels apart.

## Configuration
- **`BBOX_NOISE_FILTER_EN` defined:** `object_found` = `seen` && (count >= `min_count`). When this is 0, the box outputs load 0 but `PIXEL_COUNT` still reports the true count.
- **`BBOX_NOISE_FILTER_EN` undefined:** `object_found` = `seen`. The `min_count` parameter is ignored.

## Test plan
Bench parameters: `frame_width`=4, `frame_height`=3, `THRESHOLD`=512 unless stated.
- **Reset:** assert `areset` mid-frame, then release and stream 12 pixels of 0 → all outputs 0 before the frame. After pixel 12: `box_valid` pulses once, `object_found`=0, `PIXEL_COUNT`=0.
- **Object box:** pixels at (1,0), (3,1), (2,2) = 1023, all others 0 → after the last pixel: box x 1..3, y 0..2, `PIXEL_COUNT`=3, `object_found`=1.
- **Threshold boundary:** a single pixel (0,1) = 512 and another (2,1) = 511 → box x 0..0, y 1..1, count 1.
- **Gaps and back-to-back frames:**
  - Frame A has 3 foreground pixels and `valid_in` toggles every other cycle; frame B follows immediately with 0 foreground pixels.
  - Required: two pulses, results of A held until B's pulse, and B reports `object_found`=0.
- **`frame_start` abort:**
  - Assert it at pixel 7 of a frame whose pixel 2 was foreground, then send a clean 12-pixel frame with only (0,0) foreground.
  - Required: no pulse for the aborted frame; the result is box (0,0)-(0,0), count 1.
- **Noise filter:** with `BBOX_NOISE_FILTER_EN` defined and `min_count`=4, a frame with 3 foreground pixels → `object_found`=0, `PIXEL_COUNT`=3, box outputs 0. Undefined → `object_found`=1 with the real box.
